// File: rtl/buz_tone_pkg.sv
// Shared constants, state encoding and helpers for the piezo tone driver.
package buz_tone_pkg;

  localparam int CLK_HZ = 100_000_000;

  // Half-period count for a square wave of freq_hz at the system clock.
  function automatic int c_hz(input int freq_hz);
    return CLK_HZ / (2 * freq_hz);
  endfunction

  // Half-periods below 2 are clamped here, so the run-time logic never sees them.
  function automatic int clamp_hp(input int hp);
    return (hp < 2) ? 2 : hp;
  endfunction

  localparam int HP0_DEF = c_hz(2000);
  localparam int HP1_DEF = c_hz(2500);
  localparam int HP2_DEF = c_hz(1600);
  localparam int HP3_DEF = c_hz(1000);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } tone_state_e;

endpackage

// File: rtl/buz_tone_tone_div.sv
// Half-period counter: counts 0..hp-1 and flags the last count.
module buz_tone_tone_div #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [CNT_W-1:0] hp,
  output logic             done
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign done = (count_q == (hp - CNT_W'(1)));

  // Clearing on done as well as clr keeps the counter from ever wrapping.
  always_comb begin
    count_d = count_q + CNT_W'(1);
    if (clr || done) begin
      count_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/buz_tone.sv
// Piezo tone driver: turns the buz level into whole periods of a 50 % square
// wave at one of four pitches; start, stop and pitch change only on period edges.
module buz_tone
  import buz_tone_pkg::*;
#(
  parameter int HP0   = HP0_DEF,
  parameter int HP1   = HP1_DEF,
  parameter int HP2   = HP2_DEF,
  parameter int HP3   = HP3_DEF,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       buz,
  input  logic [1:0] sel,
  output logic       pzo,
  output logic       busy
);

  localparam logic [CNT_W-1:0] HP0_EFF = CNT_W'(clamp_hp(HP0));
  localparam logic [CNT_W-1:0] HP1_EFF = CNT_W'(clamp_hp(HP1));
  localparam logic [CNT_W-1:0] HP2_EFF = CNT_W'(clamp_hp(HP2));
  localparam logic [CNT_W-1:0] HP3_EFF = CNT_W'(clamp_hp(HP3));

  tone_state_e      state_q;
  tone_state_e      state_d;
  logic [1:0]       hp_sel_q;
  logic [1:0]       hp_sel_d;
  logic             pzo_q;
  logic             pzo_d;
  logic             busy_q;
  logic             busy_d;
  logic [CNT_W-1:0] hp;
  logic             div_clr;
  logic             div_done;

  // Half-period for the pitch latched at the start of the current period.
  always_comb begin
    hp = HP0_EFF;
    unique case (hp_sel_q)
      2'd0: hp = HP0_EFF;
      2'd1: hp = HP1_EFF;
      2'd2: hp = HP2_EFF;
      2'd3: hp = HP3_EFF;
      default: hp = HP0_EFF;
    endcase
  end

  // Holding the counter clear while idle means every period starts from 0.
  assign div_clr = (state_q == ST_IDLE);

  buz_tone_tone_div #(
    .CNT_W(CNT_W)
  ) u_tone_div (
    .clk (clk),
    .rst (rst),
    .clr (div_clr),
    .hp  (hp),
    .done(div_done)
  );

  // Next state, select latch and the values the output registers will take.
  always_comb begin
    state_d  = state_q;
    hp_sel_d = hp_sel_q;
    unique case (state_q)
      ST_IDLE: begin
        if (buz) begin
          state_d  = ST_HIGH;
          hp_sel_d = sel;
        end
      end
      ST_HIGH: begin
        if (div_done) begin
          state_d = ST_LOW;
        end
      end
      ST_LOW: begin
        if (div_done) begin
          if (buz) begin
            state_d  = ST_HIGH;
            hp_sel_d = sel;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    pzo_d  = (state_d == ST_HIGH);
    busy_d = (state_d != ST_IDLE);
  end

  // State, select latch and registered outputs; reset clears pzo at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      hp_sel_q <= 2'd0;
      pzo_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hp_sel_q <= hp_sel_d;
      pzo_q    <= pzo_d;
      busy_q   <= busy_d;
    end
  end

  assign pzo  = pzo_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_buz_tone.sv
// Self-checking bench for buz_tone: directed scenarios plus random traffic,
// compared against a queue-based model of whole square-wave periods.
module tb_buz_tone;

  logic       clk;
  logic       rst;
  logic       buz;
  logic [1:0] sel;
  logic       pzo;
  logic       busy;

  int numChecks;
  int numFails;

  // Effective half-periods for the bench parameters 3, 2, 4, 5.
  int hpTab [4] = '{3, 2, 4, 5};

  // Remaining pzo levels of the period in flight, one entry per clock.
  logic modelQ [$];
  logic expPzo;
  logic expBusy;

  buz_tone #(
    .HP0  (3),
    .HP1  (2),
    .HP2  (4),
    .HP3  (5),
    .CNT_W(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .buz (buz),
    .sel (sel),
    .pzo (pzo),
    .busy(busy)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // One rising edge of the model: an empty queue means no period is running,
  // so a sampled request schedules a full high phase followed by a full low phase.
  task automatic modelEdge(input logic b, input logic [1:0] s);
    if (modelQ.size() == 0 && b) begin
      for (int i = 0; i < hpTab[s]; i++) modelQ.push_back(1'b1);
      for (int i = 0; i < hpTab[s]; i++) modelQ.push_back(1'b0);
    end
    if (modelQ.size() > 0) begin
      expPzo  = modelQ.pop_front();
      expBusy = 1'b1;
    end else begin
      expPzo  = 1'b0;
      expBusy = 1'b0;
    end
  endtask

  // Drive inputs for one clock, advance the model and check just after the edge.
  task automatic applyStimulus(input logic b, input logic [1:0] s);
    buz = b;
    sel = s;
    @(posedge clk);
    modelEdge(b, s);
    #1;
    checkOutput("pzo", 32'(pzo), 32'(expPzo));
    checkOutput("busy", 32'(busy), 32'(expBusy));
  endtask

  // Assert reset between edges, check the asynchronous clear, then release.
  task automatic applyReset();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_async_pzo", 32'(pzo), 32'd0);
    checkOutput("rst_async_busy", 32'(busy), 32'd0);
    modelQ.delete();
    @(posedge clk);
    #1;
    checkOutput("rst_hold_pzo", 32'(pzo), 32'd0);
    checkOutput("rst_hold_busy", 32'(busy), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    numChecks = 0;
    numFails  = 0;
    rst = 1'b0;
    buz = 1'b0;
    sel = 2'd0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("reset_pzo", 32'(pzo), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    $display("[TB] reset released");

    // Idle with no request, then a sustained tone 0 request.
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 2'd0);
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 2'd0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 2'd0);

    // Single-cycle request on tone 3 still gives one full period.
    applyStimulus(1'b1, 2'd3);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 2'($urandom_range(0, 3)));

    // Select change mid-period only affects the following period.
    applyStimulus(1'b1, 2'd0);
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 2'd1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 2'd1);

    // Request drops one cycle into the high phase: no truncation.
    applyStimulus(1'b1, 2'd2);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 2'd2);

    // Reset in the low phase, then in the high phase, then a fresh period.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'd0);
    applyReset();
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 2'd0);
    applyReset();
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 2'd0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 2'd0);

    // Continuous request with the select cycling through all tones.
    for (int i = 0; i < 50; i++) applyStimulus(1'b1, 2'((i / 3) % 4));
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 2'd0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        applyReset();
      end else begin
        applyStimulus(1'($urandom_range(0, 3) != 0 ? ($urandom_range(0, 1)) : 0),
                      2'($urandom_range(0, 3)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
